// File: rtl/ucie_ctl_csr_initiator.sv
// Host-side initiator for the UCIe controller CSR block: buffers register commands in a FIFO and
// runs one setup/access handshake at a time, returning one response per command.
module ucie_ctl_csr_initiator #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_wr,
    input  logic [7:0]  i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic        o_rsp_wr,
    output logic [31:0] o_rsp_rdata,
    output logic [1:0]  o_rsp_err,
    output logic        o_P_Select,
    output logic        o_P_Enable,
    output logic [7:0]  o_P_addr,
    output logic [31:0] o_P_WDATA,
    output logic        o_P_WR,
    input  logic        i_P_Ready,
    input  logic [31:0] i_P_RDATA
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ErrOk       = 2'b00;
    localparam logic [1:0] ErrMisalign = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e r_state;
    state_e w_state_next;

    // FIFO entry layout: {wr, addr[7:0], wdata[31:0]}
    logic [40:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          r_cmd_wr;
    logic [7:0]    r_cmd_addr;
    logic [31:0]   r_cmd_wdata;
    logic [31:0]   r_rsp_rdata;
    logic [1:0]    r_rsp_err;
    logic [TW-1:0] r_tmo_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [40:0]   w_head;
    logic          w_head_misaligned;
    logic          w_tmo_hit;

    assign w_full            = (r_count == CW'(FIFO_DEPTH));
    assign w_empty           = (r_count == '0);
    assign w_push            = i_cmd_valid && !w_full;
    assign w_pop             = (r_state == StIdle) && !w_empty;
    assign w_head            = r_fifo[r_rd_ptr];
    assign w_head_misaligned = (w_head[33:32] != 2'b00);
    // This non-ready ACCESS cycle is the TIMEOUT_CYCLES-th one.
    assign w_tmo_hit         = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_state_next = w_head_misaligned ? StResp : StSetup;
                end
            end
            StSetup:  w_state_next = StAccess;
            StAccess: begin
                if (i_P_Ready || w_tmo_hit) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_cmd_ready = !w_full;
        o_P_Select  = 1'b0;
        o_P_Enable  = 1'b0;
        o_P_WR      = 1'b0;
        o_P_addr    = '0;
        o_P_WDATA   = '0;
        o_rsp_valid = 1'b0;
        o_rsp_wr    = 1'b0;
        o_rsp_rdata = '0;
        o_rsp_err   = ErrOk;
        if (r_state == StSetup || r_state == StAccess) begin
            o_P_Select = 1'b1;
            o_P_Enable = (r_state == StAccess);
            o_P_WR     = r_cmd_wr;
            o_P_addr   = r_cmd_addr;
            o_P_WDATA  = r_cmd_wdata;
        end
        if (r_state == StResp) begin
            o_rsp_valid = 1'b1;
            o_rsp_wr    = r_cmd_wr;
            o_rsp_rdata = r_rsp_rdata;
            o_rsp_err   = r_rsp_err;
        end
    end

    // Storage needs no reset: a cleared pointer/count makes stale entries unreachable.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {i_cmd_wr, i_cmd_addr, i_cmd_wdata};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_wr    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ErrOk;
            r_tmo_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            if (w_pop) begin
                r_cmd_wr    <= w_head[40];
                r_cmd_addr  <= w_head[39:32];
                r_cmd_wdata <= w_head[31:0];
                r_rsp_rdata <= '0;
                r_rsp_err   <= w_head_misaligned ? ErrMisalign : ErrOk;
                r_tmo_cnt   <= '0;
            end

            if (r_state == StAccess) begin
                if (i_P_Ready) begin
                    r_rsp_rdata <= r_cmd_wr ? 32'h0 : i_P_RDATA;
                    r_rsp_err   <= ErrOk;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (w_tmo_hit) begin
                        r_rsp_err <= ErrTimeout;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ucie_ctl_csr_initiator.sv
// Bench for ucie_ctl_csr_initiator: CSR responder model, in-order response scoreboard fed by a
// command-level reference model, and directed plus randomized scenarios.
module tb_ucie_ctl_csr_initiator;

    localparam int unsigned Depth   = 4;
    localparam int unsigned Timeout = 8;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  err;
    } rsp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_wr;
    logic [7:0]  i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic        o_rsp_wr;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_err;
    logic        o_P_Select;
    logic        o_P_Enable;
    logic [7:0]  o_P_addr;
    logic [31:0] o_P_WDATA;
    logic        o_P_WR;
    logic        i_P_Ready;
    logic [31:0] i_P_RDATA;

    int n_vec = 0;
    int n_err = 0;
    int n_rsp = 0;
    int en_cnt = 0;
    bit sel_seen = 0;
    bit csr_stall = 0;
    bit lat_fixed = 1;
    int wait_left = 0;

    logic [31:0] csr_mem [64];
    logic [31:0] ref_mem [64];
    rsp_t        exp_q [$];

    ucie_ctl_csr_initiator #(
        .FIFO_DEPTH     (Depth),
        .TIMEOUT_CYCLES (Timeout)
    ) u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_wr    (i_cmd_wr),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_wdata (i_cmd_wdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_wr    (o_rsp_wr),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_P_Select  (o_P_Select),
        .o_P_Enable  (o_P_Enable),
        .o_P_addr    (o_P_addr),
        .o_P_WDATA   (o_P_WDATA),
        .o_P_WR      (o_P_WR),
        .i_P_Ready   (i_P_Ready),
        .i_P_RDATA   (i_P_RDATA)
    );

    always #5 i_clk = ~i_clk;

    // Command-level reference: what the host should get back for each command, in order.
    function automatic rsp_t ref_cmd(input logic wr, input logic [7:0] addr,
                                     input logic [31:0] wdata);
        rsp_t r;
        r.wr    = wr;
        r.rdata = 32'h0;
        r.err   = 2'b00;
        if (addr[1:0] != 2'b00) begin
            r.err = 2'b01;
        end else if (csr_stall) begin
            r.err = 2'b10;
        end else if (wr) begin
            ref_mem[addr[7:2]] = wdata;
        end else begin
            r.rdata = ref_mem[addr[7:2]];
        end
        return r;
    endfunction

    // CSR responder: random (or zero) wait states, garbage RDATA whenever not a completing read.
    initial begin
        i_P_Ready = 1'b0;
        i_P_RDATA = 32'h0;
        forever begin
            @(negedge i_clk);
            i_P_Ready = 1'b0;
            i_P_RDATA = $urandom;
            if (o_P_Select === 1'b1 && o_P_Enable === 1'b0) begin
                wait_left = lat_fixed ? 0 : $urandom_range(0, 2);
            end else if (o_P_Select === 1'b1 && o_P_Enable === 1'b1 && !csr_stall) begin
                if (wait_left == 0) begin
                    i_P_Ready = 1'b1;
                    if (o_P_WR) begin
                        csr_mem[o_P_addr[7:2]] = o_P_WDATA;
                    end else begin
                        i_P_RDATA = csr_mem[o_P_addr[7:2]];
                    end
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Bus idle-value monitor plus select/enable observation.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_P_Select === 1'b1) sel_seen = 1'b1;
            if (o_P_Enable === 1'b1) en_cnt++;
            if (o_P_Select === 1'b0) begin
                n_vec++;
                if ({o_P_Enable, o_P_WR, o_P_addr, o_P_WDATA} !== 42'h0) begin
                    n_err++;
                    $display("FAIL bus_idle: got en=%b wr=%b addr=%h wdata=%h, required all 0",
                             o_P_Enable, o_P_WR, o_P_addr, o_P_WDATA);
                end
            end
        end
    end

    // Response scoreboard.
    initial begin
        rsp_t e;
        forever begin
            @(negedge i_clk);
            #1;
            if (o_rsp_valid === 1'b1 && i_rsp_ready === 1'b1) begin
                n_vec++;
                n_rsp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: got wr=%b rdata=%h err=%b, required none",
                             o_rsp_wr, o_rsp_rdata, o_rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_rsp_wr, o_rsp_rdata, o_rsp_err} !== e) begin
                        n_err++;
                        $display("FAIL rsp_data: got wr=%b rdata=%h err=%b, required wr=%b rdata=%h err=%b",
                                 o_rsp_wr, o_rsp_rdata, o_rsp_err, e.wr, e.rdata, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input int max_wait, output bit ok);
        @(negedge i_clk);
        i_cmd_valid = 1'b1;
        i_cmd_wr    = wr;
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        ok = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            if (i > 0) @(negedge i_clk);
            if (o_cmd_ready === 1'b1) begin
                @(posedge i_clk);
                ok = 1'b1;
                exp_q.push_back(ref_cmd(wr, addr, wdata));
            end
        end
        #1 i_cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || o_rsp_valid !== 1'b0) && n < max) begin
            @(negedge i_clk);
            #2;
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0 || o_rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic wait_rsp_valid(input int max, output int n);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (o_rsp_valid !== 1'b1 && n < max);
        #1;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        n_vec++;
        if ({o_rsp_valid, o_P_Select, o_P_Enable, o_P_WR, o_rsp_wr, o_rsp_err} !== 7'h0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, required 0",
                     {o_rsp_valid, o_P_Select, o_P_Enable, o_P_WR, o_rsp_wr, o_rsp_err});
        end
        n_vec++;
        if ({o_P_addr, o_P_WDATA, o_rsp_rdata} !== 72'h0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required 0",
                     o_P_addr, o_P_WDATA, o_rsp_rdata);
        end
        n_vec++;
        if (o_cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_cmd_ready: got %b, required 1", o_cmd_ready);
        end
        i_rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        bit ok;
        int n;
        lat_fixed = 1;
        for (int k = 0; k < 2; k++) begin
            send_cmd(k == 0, 8'h10, 32'h0000_0008, 10, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL wr_rd_accept: got ready=0, required accept");
            end
            n = 0;
            do begin
                @(negedge i_clk);
                n++;
                if (n == 2 || n == 3) begin
                    n_vec++;
                    if ({o_P_Select, o_P_Enable} !== ((n == 2) ? 2'b10 : 2'b11)) begin
                        n_err++;
                        $display("FAIL wr_rd_phase%0d: got sel/en=%b%b, required %s", n,
                                 o_P_Select, o_P_Enable, (n == 2) ? "10" : "11");
                    end
                end
            end while (o_rsp_valid !== 1'b1 && n < 20);
            n_vec++;
            if (n != 4) begin
                n_err++;
                $display("FAIL wr_rd_latency: got %0d cycles after pop, required 3", n - 1);
            end
            n_vec++;
            if (o_rsp_rdata !== ((k == 0) ? 32'h0 : 32'h8)) begin
                n_err++;
                $display("FAIL wr_rd_rdata: got %h, required %h", o_rsp_rdata,
                         (k == 0) ? 32'h0 : 32'h8);
            end
            wait_drain(20);
        end
    endtask

    task automatic test_vendor_id;
        bit ok;
        int n;
        send_cmd(1'b0, 8'h00, 32'h0, 10, ok);
        wait_rsp_valid(20, n);
        n_vec++;
        if ({o_rsp_wr, o_rsp_rdata, o_rsp_err} !== {1'b0, 32'h0000_1234, 2'b00}) begin
            n_err++;
            $display("FAIL vendor_id: got wr=%b rdata=%h err=%b, required wr=0 rdata=00001234 err=00",
                     o_rsp_wr, o_rsp_rdata, o_rsp_err);
        end
        wait_drain(20);
    endtask

    task automatic test_misaligned;
        bit ok;
        int n;
        wait_drain(20);
        sel_seen = 1'b0;
        send_cmd(1'b0, 8'h11, 32'h0, 10, ok);
        wait_rsp_valid(20, n);
        n_vec++;
        if ({o_rsp_err, o_rsp_rdata} !== {2'b01, 32'h0}) begin
            n_err++;
            $display("FAIL misaligned_rsp: got err=%b rdata=%h, required err=01 rdata=0",
                     o_rsp_err, o_rsp_rdata);
        end
        send_cmd(1'b1, 8'h02, $urandom, 10, ok);
        wait_drain(20);
        n_vec++;
        if (sel_seen !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned_bus: got select asserted, required never");
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int n;
        csr_stall = 1;
        en_cnt = 0;
        send_cmd(1'b0, 8'h20, 32'h0, 10, ok);
        wait_rsp_valid(50, n);
        n_vec++;
        if (en_cnt != Timeout) begin
            n_err++;
            $display("FAIL timeout_len: got enable high %0d cycles, required %0d", en_cnt, Timeout);
        end
        n_vec++;
        if ({o_P_Select, o_rsp_err, o_rsp_rdata} !== {1'b0, 2'b10, 32'h0}) begin
            n_err++;
            $display("FAIL timeout_rsp: got sel=%b err=%b rdata=%h, required sel=0 err=10 rdata=0",
                     o_P_Select, o_rsp_err, o_rsp_rdata);
        end
        wait_drain(20);
        csr_stall = 0;
    endtask

    task automatic test_backpressure;
        bit ok;
        int base;
        lat_fixed = 0;
        i_rsp_ready = 1'b0;
        base = n_rsp;
        for (int k = 0; k < 5; k++) begin
            send_cmd(k[0], {6'($urandom), 2'b00}, $urandom, 10, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL bp_accept%0d: got not accepted, required accept", k);
            end
        end
        n_vec++;
        if (o_cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: got cmd_ready=%b, required 0", o_cmd_ready);
        end
        send_cmd(1'b0, 8'h08, 32'h0, 5, ok);
        n_vec++;
        if (ok) begin
            n_err++;
            $display("FAIL bp_overflow: got 6th accepted while full, required stall");
        end
        @(negedge i_clk);
        i_rsp_ready = 1'b1;
        send_cmd(1'b0, 8'h08, 32'h0, 40, ok);
        wait_drain(100);
        n_vec++;
        if (n_rsp - base != 6) begin
            n_err++;
            $display("FAIL bp_count: got %0d responses, required 6", n_rsp - base);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        int base;
        csr_stall = 1;
        send_cmd(1'b0, 8'h04, 32'h0, 10, ok);
        send_cmd(1'b1, 8'h08, 32'hdead_beef, 10, ok);
        send_cmd(1'b0, 8'h0c, 32'h0, 10, ok);
        n = 0;
        while (o_P_Enable !== 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        n_vec++;
        if ({o_P_Select, o_P_Enable, o_rsp_valid, o_cmd_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_mid: got sel/en/rspv/rdy=%b, required 0001",
                     {o_P_Select, o_P_Enable, o_rsp_valid, o_cmd_ready});
        end
        exp_q.delete();
        csr_stall = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        sel_seen = 1'b0;
        base = n_rsp;
        repeat (10) @(negedge i_clk);
        #1;
        n_vec++;
        if (sel_seen !== 1'b0 || n_rsp != base) begin
            n_err++;
            $display("FAIL rst_flush: got sel_seen=%b rsps=%0d, required 0 and 0",
                     sel_seen, n_rsp - base);
        end
        send_cmd(1'b0, 8'h10, 32'h0, 10, ok);
        wait_drain(30);
        n_vec++;
        if (n_rsp - base != 1) begin
            n_err++;
            $display("FAIL rst_after: got %0d responses, required 1", n_rsp - base);
        end
    endtask

    task automatic test_random;
        bit ok;
        bit done = 0;
        logic [7:0] a;
        lat_fixed = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    a = 8'($urandom);
                    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
                    send_cmd(1'($urandom), a, $urandom, 60, ok);
                    n_vec++;
                    if (!ok) begin
                        n_err++;
                        $display("FAIL rand_accept%0d: got not accepted, required accept", k);
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge i_clk);
                    i_rsp_ready = ($urandom_range(0, 3) != 0);
                end
                @(negedge i_clk);
                i_rsp_ready = 1'b1;
            end
        join
        wait_drain(300);
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_wr    = 1'b0;
        i_cmd_addr  = 8'h0;
        i_cmd_wdata = 32'h0;
        i_rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) csr_mem[i] = $urandom;
        csr_mem[0] = 32'h0000_1234;
        ref_mem = csr_mem;

        test_reset();
        test_write_read();
        test_vendor_id();
        test_misaligned();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
